// File: rtl/frame_reg_loader.sv
`default_nettype none
// ============================================================================
// Module      : frame_reg_loader
// Description : Serial byte-stream frame receiver. It hunts for SYNC_BYTE,
//               collects NUM_BYTES payload bytes into a shadow bank, and then
//               copies the whole bank to regs_out in a single cycle. An idle
//               timeout discards the frame, as does a bad checksum when
//               checking is enabled.
//               Optional feature macro: FRAME_REG_LOADER_CHECKSUM_EN
//               (adds a trailing checksum byte and the CHECK state).
// Revision    : 1.0 - initial release
// ============================================================================
module frame_reg_loader #(
    parameter int         NUM_BYTES      = 64,
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 50000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    input  logic [7:0]             in_data,
    output logic [8*NUM_BYTES-1:0] regs_out,
    output logic                   commit,
    output logic                   frame_err,
    output logic [1:0]             err_code,
    output logic                   busy
);

    localparam int c_IDX_W = $clog2(NUM_BYTES);
    localparam int c_TO_W  = $clog2(TIMEOUT_CYCLES);

    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(NUM_BYTES - 1);
    // The timeout fires on the idle cycle that would carry the counter to
    // TIMEOUT_CYCLES-1, so compare against the value one below that.
    localparam logic [c_TO_W-1:0]  c_TO_FIRE  = c_TO_W'(TIMEOUT_CYCLES - 2);

    localparam logic [1:0] c_ERR_NONE    = 2'b00;
    localparam logic [1:0] c_ERR_CKSUM   = 2'b01;
    localparam logic [1:0] c_ERR_TIMEOUT = 2'b10;

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_PAYLOAD = 2'd1;
`ifdef FRAME_REG_LOADER_CHECKSUM_EN
    localparam logic [1:0] c_ST_CHECK   = 2'd2;
`endif
    localparam logic [1:0] c_ST_COMMIT  = 2'd3;

    logic [1:0]             r_state;
    logic [1:0]             w_state_nxt;
    logic [c_IDX_W-1:0]     r_idx;
    logic [c_TO_W-1:0]      r_tcnt;
    logic [1:0]             r_err_code;
    logic [8*NUM_BYTES-1:0] r_regs;
    logic [7:0]             r_shadow [NUM_BYTES];
    logic [8*NUM_BYTES-1:0] w_shadow_flat;

    logic                   w_sync_hit;
    logic                   w_pay_wr;
    logic                   w_timeout;
    logic                   w_cks_bad;
    logic                   w_in_frame;
    logic                   w_err_pulse;
    logic [1:0]             w_err_new;
    logic                   w_load;

`ifdef FRAME_REG_LOADER_CHECKSUM_EN
    logic [7:0]             r_sum;
    logic [7:0]             w_sum_fin;

    assign w_sum_fin  = r_sum + in_data;
    assign w_in_frame = (r_state == c_ST_PAYLOAD) || (r_state == c_ST_CHECK);
`else
    assign w_in_frame = (r_state == c_ST_PAYLOAD);
`endif

    assign w_err_pulse = w_timeout | w_cks_bad;
    assign w_err_new   = w_cks_bad ? c_ERR_CKSUM : c_ERR_TIMEOUT;
    assign w_load      = (w_state_nxt == c_ST_COMMIT);
    assign regs_out    = r_regs;

    // Shadow bank with the byte being written this cycle merged in, so the
    // final payload byte reaches regs_out on the same edge it is accepted.
    for (genvar gi = 0; gi < NUM_BYTES; gi++) begin : g_flat
        assign w_shadow_flat[8*gi +: 8] =
            (w_pay_wr && (r_idx == c_IDX_W'(gi))) ? in_data : r_shadow[gi];
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic and per-cycle events
    always_comb begin
        w_state_nxt = r_state;
        w_sync_hit  = 1'b0;
        w_pay_wr    = 1'b0;
        w_timeout   = 1'b0;
        w_cks_bad   = 1'b0;
        case (r_state)
            c_ST_IDLE, c_ST_COMMIT: begin
                // COMMIT is a single cycle and behaves like IDLE for input,
                // which lets back-to-back frames start without a gap.
                if (in_valid && (in_data == SYNC_BYTE)) begin
                    w_sync_hit  = 1'b1;
                    w_state_nxt = c_ST_PAYLOAD;
                end else begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            c_ST_PAYLOAD: begin
                if (in_valid) begin
                    w_pay_wr = 1'b1;
                    if (r_idx == c_IDX_LAST) begin
`ifdef FRAME_REG_LOADER_CHECKSUM_EN
                        w_state_nxt = c_ST_CHECK;
`else
                        w_state_nxt = c_ST_COMMIT;
`endif
                    end
                end else if (r_tcnt == c_TO_FIRE) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = c_ST_IDLE;
                end
            end
`ifdef FRAME_REG_LOADER_CHECKSUM_EN
            c_ST_CHECK: begin
                if (in_valid) begin
                    if (w_sum_fin == 8'h00) begin
                        w_state_nxt = c_ST_COMMIT;
                    end else begin
                        w_cks_bad   = 1'b1;
                        w_state_nxt = c_ST_IDLE;
                    end
                end else if (r_tcnt == c_TO_FIRE) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = c_ST_IDLE;
                end
            end
`endif
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // Outputs; forced to their idle values while reset is held
    always_comb begin
        busy      = 1'b0;
        commit    = 1'b0;
        frame_err = 1'b0;
        err_code  = c_ERR_NONE;
        if (!reset) begin
            busy      = w_in_frame;
            commit    = (r_state == c_ST_COMMIT);
            frame_err = w_err_pulse;
            err_code  = w_err_pulse ? w_err_new : r_err_code;
        end
    end

    // Payload byte index: cleared on sync, advanced per payload byte
    always_ff @(posedge clk) begin
        if (reset) begin
            r_idx <= '0;
        end else if (w_sync_hit) begin
            r_idx <= '0;
        end else if (w_pay_wr) begin
            r_idx <= (r_idx == c_IDX_LAST) ? '0 : r_idx + c_IDX_W'(1);
        end
    end

`ifdef FRAME_REG_LOADER_CHECKSUM_EN
    // Running modulo-256 sum of the payload bytes
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sum <= 8'h00;
        end else if (w_sync_hit) begin
            r_sum <= 8'h00;
        end else if (w_pay_wr) begin
            r_sum <= w_sum_fin;
        end
    end
`endif

    // Idle-cycle counter, live only while a frame is in progress
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tcnt <= '0;
        end else if (w_in_frame && !in_valid && !w_timeout) begin
            r_tcnt <= r_tcnt + c_TO_W'(1);
        end else begin
            r_tcnt <= '0;
        end
    end

    // Shadow bank capture; contents are don't-care outside a frame
    always_ff @(posedge clk) begin
        if (w_pay_wr) begin
            r_shadow[r_idx] <= in_data;
        end
    end

    // Committed bank, updated on the edge that enters COMMIT
    always_ff @(posedge clk) begin
        if (reset) begin
            r_regs <= '0;
        end else if (w_load) begin
            r_regs <= w_shadow_flat;
        end
    end

    // Sticky cause of the most recent discard
    always_ff @(posedge clk) begin
        if (reset) begin
            r_err_code <= c_ERR_NONE;
        end else if (w_err_pulse) begin
            r_err_code <= w_err_new;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_frame_reg_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_frame_reg_loader
// Description : Directed self-checking bench for frame_reg_loader with
//               NUM_BYTES=4 and TIMEOUT_CYCLES=16. Builds with or without
//               FRAME_REG_LOADER_CHECKSUM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_frame_reg_loader;

    localparam int NB = 4;
    localparam int TO = 16;

    logic          clk      = 1'b0;
    logic          reset    = 1'b1;
    logic          in_valid = 1'b0;
    logic [7:0]    in_data  = 8'h00;
    logic [8*NB-1:0] regs_out;
    logic          commit;
    logic          frame_err;
    logic [1:0]    err_code;
    logic          busy;

    int n_checks = 0;
    int n_fail   = 0;
    int n_commit = 0;
    int n_ferr   = 0;
    int c0;
    int f0;

    logic        s_commit;
    logic        s_ferr;
    logic        s_busy;
    logic [1:0]  s_err;
    logic [31:0] s_regs;

    always #5 clk = ~clk;

    frame_reg_loader #(
        .NUM_BYTES      (NB),
        .SYNC_BYTE      (8'hA5),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .regs_out  (regs_out),
        .commit    (commit),
        .frame_err (frame_err),
        .err_code  (err_code),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock cycle: present the input, sample outputs mid-cycle.
    task automatic drive(input logic v, input logic [7:0] d);
        in_valid = v;
        in_data  = d;
        @(negedge clk);
        s_commit = commit;
        s_ferr   = frame_err;
        s_busy   = busy;
        s_err    = err_code;
        s_regs   = regs_out;
        if (commit)    n_commit++;
        if (frame_err) n_ferr++;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

`ifdef FRAME_REG_LOADER_CHECKSUM_EN
    function automatic logic [7:0] cks(input logic [31:0] p);
        logic [7:0] s;
        s = p[7:0] + p[15:8] + p[23:16] + p[31:24];
        return 8'h00 - s;
    endfunction
`endif

    // SYNC, four payload bytes (byte 0 first), plus checksum when enabled.
    task automatic send_frame(input logic [31:0] p);
        drive(1'b1, 8'hA5);
        for (int i = 0; i < NB; i++) drive(1'b1, p[8*i +: 8]);
`ifdef FRAME_REG_LOADER_CHECKSUM_EN
        drive(1'b1, cks(p));
`endif
    endtask

    initial begin
        // Reset state
        repeat (3) drive(1'b0, 8'h00);
        check("rst_regs",   s_regs,           32'h0);
        check("rst_commit", 32'(s_commit),    32'd0);
        check("rst_ferr",   32'(s_ferr),      32'd0);
        check("rst_err",    32'(s_err),       32'd0);
        check("rst_busy",   32'(s_busy),      32'd0);
        reset = 1'b0;

        // Basic frame: commit exactly one cycle after the final byte
        c0 = n_commit;
        send_frame(32'h04030201);
        check("t1_busy_last", 32'(s_busy), 32'd1);
        check("t1_no_early",  32'(n_commit - c0), 32'd0);
        drive(1'b0, 8'h00);
        check("t1_commit",    32'(s_commit), 32'd1);
        check("t1_regs",      s_regs, 32'h04030201);
        drive(1'b0, 8'h00);
        check("t1_pulse_w",   32'(s_commit), 32'd0);
        check("t1_no_ferr",   32'(n_ferr), 32'd0);

`ifdef FRAME_REG_LOADER_CHECKSUM_EN
        // Bad checksum: 01+02+03+04+F7 = 0x01
        c0 = n_commit;
        drive(1'b1, 8'hA5);
        drive(1'b1, 8'h01);
        drive(1'b1, 8'h02);
        drive(1'b1, 8'h03);
        drive(1'b1, 8'h04);
        drive(1'b1, 8'hF7);
        check("cks_ferr",     32'(s_ferr), 32'd1);
        check("cks_code",     32'(s_err), 32'd1);
        drive(1'b0, 8'h00);
        check("cks_ferr_w",   32'(s_ferr), 32'd0);
        check("cks_code_hold", 32'(s_err), 32'd1);
        check("cks_regs",     s_regs, 32'h04030201);
        check("cks_no_commit", 32'(n_commit - c0), 32'd0);
`endif

        // SYNC value inside the payload is data
        send_frame(32'h010000A5);
        drive(1'b0, 8'h00);
        check("syncdata_commit", 32'(s_commit), 32'd1);
        check("syncdata_regs",   s_regs, 32'h010000A5);

        // Leading garbage ignored
        drive(1'b1, 8'h33);
        check("lead_busy", 32'(s_busy), 32'd0);
        drive(1'b1, 8'h7E);
        send_frame(32'h40302010);
        drive(1'b0, 8'h00);
        check("lead_commit", 32'(s_commit), 32'd1);
        check("lead_regs",   s_regs, 32'h40302010);

        // Timeout: error pulse on the 15th idle cycle
        f0 = n_ferr;
        drive(1'b1, 8'hA5);
        drive(1'b1, 8'h01);
        drive(1'b1, 8'h02);
        for (int k = 1; k <= 16; k++) begin
            drive(1'b0, 8'h00);
            if (k == 14) check("to_early", 32'(s_ferr), 32'd0);
            if (k == 15) begin
                check("to_ferr", 32'(s_ferr), 32'd1);
                check("to_code", 32'(s_err), 32'd2);
            end
            if (k == 16) check("to_idle_busy", 32'(s_busy), 32'd0);
        end
        check("to_one_pulse", 32'(n_ferr - f0), 32'd1);
        check("to_regs_kept", s_regs, 32'h40302010);
        send_frame(32'h44332211);
        drive(1'b0, 8'h00);
        check("to_next_commit", 32'(s_commit), 32'd1);
        check("to_next_regs",   s_regs, 32'h44332211);
        check("to_code_held",   32'(s_err), 32'd2);

        // Byte on the cycle the timeout would fire is accepted
        f0 = n_ferr;
        drive(1'b1, 8'hA5);
        drive(1'b1, 8'h01);
        repeat (14) drive(1'b0, 8'h00);
        drive(1'b1, 8'h02);
        check("edge_ferr", 32'(s_ferr), 32'd0);
        drive(1'b1, 8'h03);
        check("edge_busy", 32'(s_busy), 32'd1);
        drive(1'b1, 8'h04);
`ifdef FRAME_REG_LOADER_CHECKSUM_EN
        drive(1'b1, 8'hF6);
`endif
        drive(1'b0, 8'h00);
        check("edge_commit", 32'(s_commit), 32'd1);
        check("edge_regs",   s_regs, 32'h04030201);
        check("edge_no_ferr", 32'(n_ferr - f0), 32'd0);

        // Reset mid-frame
        c0 = n_commit;
        f0 = n_ferr;
        drive(1'b1, 8'hA5);
        drive(1'b1, 8'h01);
        reset = 1'b1;
        drive(1'b0, 8'h00);
        check("mid_rst_busy", 32'(s_busy), 32'd0);
        drive(1'b0, 8'h00);
        check("mid_rst_regs", s_regs, 32'h0);
        check("mid_rst_code", 32'(s_err), 32'd0);
        reset = 1'b0;
        check("mid_rst_no_pulse", 32'((n_commit - c0) + (n_ferr - f0)), 32'd0);
        // AA+BB+CC+DD = 0x30E, so a correct checksum byte is 0xF2
        send_frame(32'hDDCCBBAA);
        drive(1'b0, 8'h00);
        check("mid_rst_commit", 32'(s_commit), 32'd1);
        check("mid_rst_regs2",  s_regs, 32'hDDCCBBAA);

        // Back-to-back frames with no idle cycle
        c0 = n_commit;
        send_frame(32'h0A0B0C0D);
        send_frame(32'hF0E0D0C0);
        drive(1'b0, 8'h00);
        check("b2b_commits", 32'(n_commit - c0), 32'd2);
        check("b2b_regs",    s_regs, 32'hF0E0D0C0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
